// File: rtl/reg_list_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_list_sequencer_pkg
//   Shared definitions for the LDM/STM-style register list sequencer:
//   default geometry of the register file, transfer direction codes and
//   the sequencer state encoding.
// ---------------------------------------------------------------------------
package reg_list_sequencer_pkg;

  // Default geometry: 32 registers of 64 bits, 5-bit register index.
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 64;

  // Transfer direction as sampled on the dir input at start.
  localparam logic DIR_STORE = 1'b0;
  localparam logic DIR_LOAD  = 1'b1;

  // Sequencer states. STORE walks RD_ISSUE -> RD_CAPT -> RD_HOLD per
  // register. LOAD walks LD_WAIT -> LD_WRITE per register.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_RD_HOLD  = 3'd3,
    ST_LD_WAIT  = 3'd4,
    ST_LD_WRITE = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/reg_list_sequencer_lsb_prio_enc.sv
// ---------------------------------------------------------------------------
// lsb_prio_enc
//   Combinational lowest-set-bit priority encoder.
//   Ports:
//     vec      in   N   bit vector to search
//     idx      out  W   index of the lowest set bit (0 when none is set)
//     any_set  out  1   high when at least one bit of vec is set
// ---------------------------------------------------------------------------
module lsb_prio_enc #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_set
);

  // Scan from the top down so the last hit, which wins, is the lowest
  // set bit.
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx     = W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// ---------------------------------------------------------------------------
// reg_list_sequencer
//   Block-transfer master for the register file (LDM/STM style). On start
//   it walks a register bitmask, lowest index first.
//     STORE: reads each selected register and streams it out.
//     LOAD : accepts one stream word per selected register and writes it.
//   Ports:
//     clk, reset            clock and asynchronous active-low reset
//     start, dir, reg_mask  transfer request; dir/mask captured at start
//     busy, done            busy from the cycle after start; done pulse
//     xfer_count            registers transferred so far (held after done)
//     out_data/valid/ready  STORE output stream
//     in_data/valid/ready   LOAD input stream
//     rf_readreg/readdata   register file read port (1-cycle latency)
//     rf_writereg/writedata/reg_write  register file write port
// ---------------------------------------------------------------------------
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int NREGS = reg_list_sequencer_pkg::NREGS,
  parameter int AW    = reg_list_sequencer_pkg::AW,
  parameter int DW    = reg_list_sequencer_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [NREGS-1:0] reg_mask,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      xfer_count,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [AW-1:0]    rf_readreg,
  input  logic [DW-1:0]    rf_readdata,
  output logic [AW-1:0]    rf_writereg,
  output logic [DW-1:0]    rf_writedata,
  output logic             rf_reg_write
);

  state_t           state;

  // mask_q holds the registers not yet picked up; the register currently
  // being transferred has already been removed from it and lives in
  // cur_idx. This lets the single encoder look one register ahead, so
  // the next read index is ready on the same edge that finishes the
  // current word.
  logic [NREGS-1:0] mask_q;
  logic [AW-1:0]    cur_idx;

  logic [NREGS-1:0] enc_in;
  logic [AW-1:0]    enc_idx;
  logic             enc_any;
  logic [NREGS-1:0] enc_bit;

  // In IDLE the encoder looks straight at the incoming mask so the first
  // register index is known at the start edge; afterwards it looks at the
  // remaining-mask register.
  assign enc_in  = (state == ST_IDLE) ? reg_mask : mask_q;
  assign enc_bit = {{(NREGS-1){1'b0}}, 1'b1} << enc_idx;

  lsb_prio_enc #(
    .N (NREGS),
    .W (AW)
  ) u_prio_enc (
    .vec     (enc_in),
    .idx     (enc_idx),
    .any_set (enc_any)
  );

  // The load stream may hand over a word only while waiting for one.
  assign in_ready = (state == ST_LD_WAIT);

  // Sequencer: one registered state machine driving every output except
  // in_ready. rf_readreg is loaded on the edge that enters RD_ISSUE so the
  // register file sees it during RD_ISSUE and its registered read data is
  // valid in RD_CAPT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      cur_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      xfer_count   <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      rf_readreg   <= '0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
      rf_reg_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            xfer_count <= '0;
            mask_q     <= reg_mask & ~enc_bit;
            cur_idx    <= enc_idx;
            if (!enc_any) begin
              state <= ST_DONE;
            end else if (dir == DIR_STORE) begin
              rf_readreg <= enc_idx;
              state      <= ST_RD_ISSUE;
            end else begin
              state <= ST_LD_WAIT;
            end
          end
        end

        ST_RD_ISSUE: begin
          state <= ST_RD_CAPT;
        end

        ST_RD_CAPT: begin
          out_data  <= rf_readdata;
          out_valid <= 1'b1;
          state     <= ST_RD_HOLD;
        end

        ST_RD_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            xfer_count <= xfer_count + (AW+1)'(1);
            if (enc_any) begin
              rf_readreg <= enc_idx;
              cur_idx    <= enc_idx;
              mask_q     <= mask_q & ~enc_bit;
              state      <= ST_RD_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_LD_WAIT: begin
          if (in_valid) begin
            rf_writereg  <= cur_idx;
            rf_writedata <= in_data;
            rf_reg_write <= 1'b1;
            state        <= ST_LD_WRITE;
          end
        end

        ST_LD_WRITE: begin
          rf_reg_write <= 1'b0;
          xfer_count   <= xfer_count + (AW+1)'(1);
          if (enc_any) begin
            cur_idx <= enc_idx;
            mask_q  <= mask_q & ~enc_bit;
            state   <= ST_LD_WAIT;
          end else begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_list_sequencer
//   Self-checking bench: a behavioural register file (mem[i]=i at power-up,
//   registered read), a reference copy of its expected contents, and
//   scoreboard queues for expected store words and register writes.
// ---------------------------------------------------------------------------
module tb_reg_list_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [31:0] reg_mask;
  logic        busy;
  logic        done;
  logic [5:0]  xfer_count;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rf_readreg;
  logic [63:0] rf_readdata;
  logic [4:0]  rf_writereg;
  logic [63:0] rf_writedata;
  logic        rf_reg_write;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:31];
  logic [63:0] ref_mem [0:31];
  logic        mem_ready = 1'b0;

  logic [63:0] exp_q [$];
  logic [68:0] wr_q [$];
  logic [63:0] ld_words [0:3];

  int cnt_ov = 0;
  int cnt_ir = 0;
  int cnt_wr = 0;
  int cnt_done = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  always #5 clk = ~clk;

  reg_list_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dir          (dir),
    .reg_mask     (reg_mask),
    .busy         (busy),
    .done         (done),
    .xfer_count   (xfer_count),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rf_readreg   (rf_readreg),
    .rf_readdata  (rf_readdata),
    .rf_writereg  (rf_writereg),
    .rf_writedata (rf_writedata),
    .rf_reg_write (rf_reg_write)
  );

  // Register file model: contents come up as mem[i]=i on the first edge,
  // read data is registered (one cycle after rf_readreg).
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'(i);
      mem_ready <= 1'b1;
    end else if (rf_reg_write) begin
      mem[rf_writereg] <= rf_writedata;
    end
    rf_readdata <= mem[rf_readreg];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Stream and write monitor, sampling mid-cycle.
  always @(negedge clk) begin
    logic        have;
    logic [63:0] e;
    logic [68:0] w;
    if (reset) begin
      if (out_valid) cnt_ov++;
      if (in_ready) cnt_ir++;
      if (rf_reg_write) cnt_wr++;
      if (done) cnt_done++;
      if (prev_stall) checkOutput("stall_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        have = (exp_q.size() != 0);
        checkOutput("store_expected", 64'(have), 64'd1);
        if (have) begin
          e = exp_q.pop_front();
          checkOutput("store_word", out_data, e);
        end
      end
      if (rf_reg_write) begin
        have = (wr_q.size() != 0);
        checkOutput("write_expected", 64'(have), 64'd1);
        if (have) begin
          w = wr_q.pop_front();
          checkOutput("write_reg", 64'(rf_writereg), 64'(w[68:64]));
          checkOutput("write_data", rf_writedata, w[63:0]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic [31:0] m,
                               input logic hold);
    dir      = d;
    reg_mask = m;
    start    = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int ready_div,
                                input string tag);
    for (int c = 0; c < budget; c++) begin
      out_ready = (ready_div <= 1) ? 1'b1 : ((c % ready_div) == 0);
      tick();
      if (done) break;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic run_load(input int n, input int budget, input string tag);
    int   k;
    logic acc;
    k        = 0;
    in_valid = 1'b1;
    in_data  = ld_words[0];
    for (int c = 0; c < budget; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        k++;
        if (k < n) in_data = ld_words[k];
        else in_valid = 1'b0;
      end
      if (done) break;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int snap_ov, snap_ir, snap_wr, snap_done;
    reset     = 1'b0;
    start     = 1'b0;
    dir       = 1'b0;
    reg_mask  = '0;
    out_ready = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'(i);

    // Reset values
    repeat (3) tick();
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_out_valid", 64'(out_valid), 0);
    checkOutput("rst_in_ready", 64'(in_ready), 0);
    checkOutput("rst_reg_write", 64'(rf_reg_write), 0);
    checkOutput("rst_xfer_count", 64'(xfer_count), 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_readreg", 64'(rf_readreg), 0);
    checkOutput("rst_writereg", 64'(rf_writereg), 0);
    checkOutput("rst_writedata", rf_writedata, 0);
    reset = 1'b1;
    tick();

    // STORE 0x15 with out_ready held high: words 0,2,4
    exp_q.push_back(ref_mem[0]);
    exp_q.push_back(ref_mem[2]);
    exp_q.push_back(ref_mem[4]);
    applyStimulus(1'b0, 32'h0000_0015, 1'b0);
    checkOutput("st15_busy", 64'(busy), 1);
    run_until_done(40, 1, "st15");
    checkOutput("st15_count", 64'(xfer_count), 3);
    checkOutput("st15_busy_at_done", 64'(busy), 0);
    checkOutput("st15_drained", 64'(exp_q.size()), 0);
    tick();
    checkOutput("st15_done_pulse", 64'(done), 0);
    checkOutput("st15_busy_after", 64'(busy), 0);
    checkOutput("st15_count_held", 64'(xfer_count), 3);

    // LOAD 0x8000_0001: writes reg 0 then reg 31
    ld_words[0] = 64'hAAAA;
    ld_words[1] = 64'hBBBB;
    wr_q.push_back({5'd0, 64'hAAAA});
    wr_q.push_back({5'd31, 64'hBBBB});
    applyStimulus(1'b1, 32'h8000_0001, 1'b0);
    run_load(2, 40, "ld");
    checkOutput("ld_count", 64'(xfer_count), 2);
    checkOutput("ld_drained", 64'(wr_q.size()), 0);
    tick();
    ref_mem[0]  = 64'hAAAA;
    ref_mem[31] = 64'hBBBB;
    checkOutput("ld_mem0", mem[0], ref_mem[0]);
    checkOutput("ld_mem31", mem[31], ref_mem[31]);
    checkOutput("ld_mem1", mem[1], ref_mem[1]);

    // STORE all 32 registers, out_ready high one cycle in three
    for (int i = 0; i < 32; i++) exp_q.push_back(ref_mem[i]);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);
    run_until_done(600, 3, "full");
    checkOutput("full_count", 64'(xfer_count), 32);
    checkOutput("full_drained", 64'(exp_q.size()), 0);
    tick();

    // Empty mask: done two cycles after start, no transfer activity
    snap_ov = cnt_ov; snap_ir = cnt_ir; snap_wr = cnt_wr;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("m0_done_c1", 64'(done), 0);
    checkOutput("m0_busy_c1", 64'(busy), 1);
    tick();
    checkOutput("m0_done_c2", 64'(done), 1);
    checkOutput("m0_busy_c2", 64'(busy), 0);
    checkOutput("m0_count", 64'(xfer_count), 0);
    tick();
    checkOutput("m0_done_c3", 64'(done), 0);
    checkOutput("m0_no_out_valid", 64'(cnt_ov - snap_ov), 0);
    checkOutput("m0_no_in_ready", 64'(cnt_ir - snap_ir), 0);
    checkOutput("m0_no_write", 64'(cnt_wr - snap_wr), 0);

    // start held while busy, mask/dir changed mid-run: original only
    exp_q.push_back(ref_mem[1]);
    exp_q.push_back(ref_mem[2]);
    applyStimulus(1'b0, 32'h0000_0006, 1'b1);
    reg_mask = 32'hFF00_FF00;
    dir      = 1'b1;
    run_until_done(60, 1, "hold");
    start = 1'b0;
    checkOutput("hold_count", 64'(xfer_count), 2);
    checkOutput("hold_drained", 64'(exp_q.size()), 0);
    tick();
    checkOutput("hold_no_restart", 64'(busy), 0);
    tick();
    checkOutput("hold_idle", 64'(busy), 0);

    // Reset during LOAD after the first of three writes
    ld_words[0] = 64'h1111_2222_3333_4444;
    ld_words[1] = 64'h5555;
    wr_q.push_back({5'd2, ld_words[0]});
    in_valid = 1'b1;
    in_data  = ld_words[0];
    applyStimulus(1'b1, 32'h0000_0124, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (rf_reg_write) break;
      tick();
    end
    checkOutput("rl_first_write", 64'(rf_reg_write), 1);
    tick();
    in_data   = ld_words[1];
    snap_done = cnt_done;
    reset     = 1'b0;
    #1;
    checkOutput("rl_busy", 64'(busy), 0);
    checkOutput("rl_in_ready", 64'(in_ready), 0);
    checkOutput("rl_reg_write", 64'(rf_reg_write), 0);
    checkOutput("rl_count", 64'(xfer_count), 0);
    checkOutput("rl_writereg", 64'(rf_writereg), 0);
    checkOutput("rl_writedata", rf_writedata, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("rl_no_done", 64'(cnt_done - snap_done), 0);
    checkOutput("rl_drained", 64'(wr_q.size()), 0);
    ref_mem[2] = ld_words[0];
    checkOutput("rl_mem2", mem[2], ref_mem[2]);
    checkOutput("rl_mem5", mem[5], ref_mem[5]);
    checkOutput("rl_mem8", mem[8], ref_mem[8]);

    // Normal transfer after the abandoned one
    exp_q.push_back(ref_mem[2]);
    exp_q.push_back(ref_mem[5]);
    applyStimulus(1'b0, 32'h0000_0024, 1'b0);
    run_until_done(40, 1, "post");
    checkOutput("post_count", 64'(xfer_count), 2);
    checkOutput("post_drained", 64'(exp_q.size()), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
